// File: rtl/rx_mensagem_sonar_7e1_pkg.sv
// Shared definitions for the sonar message receiver: ASCII codes,
// parser/UART state encodings and small character-classification helpers.
package rx_mensagem_sonar_7e1_pkg;

   localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;
   localparam logic [6:0] ASCII_CERQUILHA = 7'h23;
   localparam logic [6:0] ASCII_ZERO      = 7'h30;
   localparam logic [6:0] ASCII_NOVE      = 7'h39;

   // Parser state codes, also visible on db_estado
   typedef enum logic [3:0] {
      ESPERA_ANG0 = 4'd0,
      ANG1        = 4'd1,
      ANG2        = 4'd2,
      VIRGULA     = 4'd3,
      DIST0       = 4'd4,
      DIST1       = 4'd5,
      DIST2       = 4'd6,
      CERQUILHA   = 4'd7,
      SINCRONIZA  = 4'd8
   } parser_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_BITS  = 2'd2
   } rx_state_t;

   function automatic logic is_digit(input logic [6:0] c);
      return (c >= ASCII_ZERO) && (c <= ASCII_NOVE);
   endfunction

   // True when c is the character the message format expects in state st
   function automatic logic char_expected(input parser_state_t st, input logic [6:0] c);
      case (st)
         VIRGULA:    return c == ASCII_VIRGULA;
         CERQUILHA:  return c == ASCII_CERQUILHA;
         SINCRONIZA: return 1'b0;
         default:    return is_digit(c);
      endcase
   endfunction

   // Field that follows st in a well-formed message
   function automatic parser_state_t next_field(input parser_state_t st);
      case (st)
         ESPERA_ANG0: return ANG1;
         ANG1:        return ANG2;
         ANG2:        return VIRGULA;
         VIRGULA:     return DIST0;
         DIST0:       return DIST1;
         DIST1:       return DIST2;
         DIST2:       return CERQUILHA;
         default:     return ESPERA_ANG0;
      endcase
   endfunction

endpackage

// File: rtl/rx_mensagem_sonar_7e1_serial.sv
// Bit-level 7E1 UART receiver: input synchroniser, baud timing, shift
// register, parity/stop check and a one-cycle character strobe.
module rx_mensagem_sonar_7e1_serial
   import rx_mensagem_sonar_7e1_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       entrada_serial,
   output logic       strobe,
   output logic [6:0] char_rx,
   output logic       bad
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

   rx_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       idx, idx_n;
   logic [7:0]       shift, shift_n;
   logic             strobe_n, bad_n;
   logic [6:0]       char_n;
   logic             rx_meta, rx_sync, rx_prev;

   // Double-flop the line and keep one older sample for edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= entrada_serial;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver state and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         strobe  <= 1'b0;
         char_rx <= '0;
         bad     <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shift   <= shift_n;
         strobe  <= strobe_n;
         char_rx <= char_n;
         bad     <= bad_n;
      end
   end

   // Start detect, mid-bit sampling of 7 data + parity + stop
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      shift_n  = shift;
      strobe_n = 1'b0;
      char_n   = char_rx;
      bad_n    = bad;
      case (state)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_n = RX_START;
               cnt_n   = '0;
            end
         end
         RX_START: begin
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               idx_n = '0;
               // A line already back high at half bit was a glitch
               state_n = rx_sync ? RX_IDLE : RX_BITS;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RX_BITS: begin
            if (cnt == FULL_LAST) begin
               cnt_n = '0;
               if (idx == 4'd8) begin
                  state_n  = RX_IDLE;
                  strobe_n = 1'b1;
                  char_n   = shift[6:0];
                  bad_n    = (^shift) | ~rx_sync;
               end else begin
                  shift_n = {rx_sync, shift[7:1]};
                  idx_n   = idx + 4'd1;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/rx_mensagem_sonar_7e1.sv
// Sonar message receiver: parses "AAA,DDD#" from a 7E1 serial line into
// BCD angle/distance words with pronto/erro pulses.
// Optional macro SONAR_RX_TIMEOUT_EN enables the inter-character gap timeout.
module rx_mensagem_sonar_7e1
   import rx_mensagem_sonar_7e1_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 434
`ifdef SONAR_RX_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT  = 5_000_000
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        entrada_serial,
   output logic [11:0] angulo,
   output logic [11:0] distancia,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado
);

   logic          strobe, bad;
   logic [6:0]    ch;
   parser_state_t state, state_n;
   logic [11:0]   sh_ang, sh_ang_n, sh_dist, sh_dist_n;
   logic [11:0]   angulo_n, distancia_n;
   logic          pronto_n, erro_n;
   logic          good_hash_c;

`ifdef SONAR_RX_TIMEOUT_EN
   localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
   logic [GAP_W-1:0] gap, gap_n;
`endif

   rx_mensagem_sonar_7e1_serial #(.BAUD_DIV(BAUD_DIV)) u_serial (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .strobe         (strobe),
      .char_rx        (ch),
      .bad            (bad)
   );

   assign db_estado   = state;
   assign good_hash_c = !bad && (ch == ASCII_CERQUILHA);

   // Parser state, shadow fields and published outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ESPERA_ANG0;
         sh_ang    <= '0;
         sh_dist   <= '0;
         angulo    <= '0;
         distancia <= '0;
         pronto    <= 1'b0;
         erro      <= 1'b0;
`ifdef SONAR_RX_TIMEOUT_EN
         gap       <= '0;
`endif
      end else begin
         state     <= state_n;
         sh_ang    <= sh_ang_n;
         sh_dist   <= sh_dist_n;
         angulo    <= angulo_n;
         distancia <= distancia_n;
         pronto    <= pronto_n;
         erro      <= erro_n;
`ifdef SONAR_RX_TIMEOUT_EN
         gap       <= gap_n;
`endif
      end
   end

   // Next-state: accept the expected field, otherwise reject and resync on '#'
   always_comb begin
      state_n     = state;
      sh_ang_n    = sh_ang;
      sh_dist_n   = sh_dist;
      angulo_n    = angulo;
      distancia_n = distancia;
      pronto_n    = 1'b0;
      erro_n      = 1'b0;
      if (strobe) begin
         if (state == SINCRONIZA) begin
            if (good_hash_c) state_n = ESPERA_ANG0;
         end else if (!bad && char_expected(state, ch)) begin
            case (state)
               ESPERA_ANG0, ANG1, ANG2: sh_ang_n  = {sh_ang[7:0], ch[3:0]};
               DIST0, DIST1, DIST2:     sh_dist_n = {sh_dist[7:0], ch[3:0]};
               CERQUILHA: begin
                  angulo_n    = sh_ang;
                  distancia_n = sh_dist;
                  pronto_n    = 1'b1;
               end
               default: ;
            endcase
            state_n = next_field(state);
         end else begin
            erro_n    = 1'b1;
            sh_ang_n  = '0;
            sh_dist_n = '0;
            state_n   = good_hash_c ? ESPERA_ANG0 : SINCRONIZA;
         end
      end
`ifdef SONAR_RX_TIMEOUT_EN
      // Gap timer only runs while a frame is partially received
      gap_n = '0;
      if (!strobe && state != ESPERA_ANG0 && state != SINCRONIZA) begin
         if (gap == GAP_W'(TIMEOUT - 1)) begin
            erro_n    = 1'b1;
            sh_ang_n  = '0;
            sh_dist_n = '0;
            state_n   = ESPERA_ANG0;
         end else begin
            gap_n = gap + GAP_W'(1);
         end
      end
`endif
   end

endmodule

// File: tb/tb_rx_mensagem_sonar_7e1.sv
// Self-checking bench for rx_mensagem_sonar_7e1 (optionally with SONAR_RX_TIMEOUT_EN).
module tb_rx_mensagem_sonar_7e1;
   import rx_mensagem_sonar_7e1_pkg::*;

   localparam int unsigned BAUD = 16;
   localparam int unsigned TMO  = 2000;

   logic        clock = 1'b0;
   logic        reset;
   logic        entrada_serial;
   logic [11:0] angulo, distancia;
   logic        pronto, erro;
   logic [3:0]  db_estado;

   int tests_run = 0;
   int tests_failed = 0;

   // Observed pulse counts
   int obs_pronto = 0;
   int obs_erro = 0;
   int obs_both = 0;

   // Reference model: frame text accepted so far, resync flag, expected results
   logic [7:0]  m_buf[$];
   bit          m_sync = 1'b0;
   int          exp_pronto = 0;
   int          exp_erro = 0;
   logic [11:0] m_ang = '0;
   logic [11:0] m_dist = '0;

   always #5 clock = ~clock;

   rx_mensagem_sonar_7e1 #(
      .BAUD_DIV(BAUD)
`ifdef SONAR_RX_TIMEOUT_EN
      ,
      .TIMEOUT(TMO)
`endif
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .angulo         (angulo),
      .distancia      (distancia),
      .pronto         (pronto),
      .erro           (erro),
      .db_estado      (db_estado)
   );

   always @(negedge clock) begin
      if (pronto) obs_pronto++;
      if (erro) obs_erro++;
      if (pronto && erro) obs_both++;
   end

   // Message format "DDD,DDD#": which character belongs at position pos
   function automatic bit fits(int pos, logic [7:0] c);
      if (pos == 3) return c == 8'h2C;
      if (pos == 7) return c == 8'h23;
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic void model_char(logic [7:0] c, bit bad);
      bit good_hash;
      good_hash = !bad && (c == 8'h23);
      if (m_sync) begin
         if (good_hash) m_sync = 1'b0;
      end else if (!bad && fits(m_buf.size(), c)) begin
         m_buf.push_back(c);
         if (m_buf.size() == 8) begin
            exp_pronto++;
            m_ang  = 12'((m_buf[0] - 48) * 256 + (m_buf[1] - 48) * 16 + (m_buf[2] - 48));
            m_dist = 12'((m_buf[4] - 48) * 256 + (m_buf[5] - 48) * 16 + (m_buf[6] - 48));
            m_buf.delete();
         end
      end else begin
         exp_erro++;
         m_buf.delete();
         m_sync = !good_hash;
      end
   endfunction

   function automatic void model_reset();
      m_buf.delete();
      m_sync = 1'b0;
      m_ang  = '0;
      m_dist = '0;
   endfunction

   task automatic drive_bit(input logic b);
      entrada_serial = b;
      repeat (BAUD) @(negedge clock);
   endtask

   task automatic send_char(input logic [7:0] c, input bit flip_par, input bit bad_stop);
      logic [6:0] d;
      d = c[6:0];
      drive_bit(1'b0);
      for (int i = 0; i < 7; i++) drive_bit(d[i]);
      drive_bit((^d) ^ flip_par);
      drive_bit(!bad_stop);
      if (bad_stop) drive_bit(1'b1);
      model_char(c, flip_par || bad_stop);
   endtask

   task automatic send_text(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send_char(s[i], 1'b0, 1'b0);
         repeat (gap) @(negedge clock);
      end
   endtask

   task automatic test_reset();
      entrada_serial = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      tests_run++; if (angulo !== 12'h000) begin tests_failed++; $display("FAIL reset_angulo: got %h expected 000", angulo); end
      tests_run++; if (distancia !== 12'h000) begin tests_failed++; $display("FAIL reset_distancia: got %h expected 000", distancia); end
      tests_run++; if ({pronto, erro} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 00", {pronto, erro}); end
      tests_run++; if (db_estado !== 4'(ESPERA_ANG0)) begin tests_failed++; $display("FAIL reset_estado: got %0d expected %0d", db_estado, ESPERA_ANG0); end
   endtask

   task automatic test_single_frame();
      send_text("090,123#", 2);
      repeat (4) @(negedge clock);
      tests_run++; if (angulo !== 12'h090) begin tests_failed++; $display("FAIL single_angulo: got %h expected 090", angulo); end
      tests_run++; if (distancia !== 12'h123) begin tests_failed++; $display("FAIL single_distancia: got %h expected 123", distancia); end
      tests_run++; if (obs_pronto !== exp_pronto) begin tests_failed++; $display("FAIL single_pronto: got %0d expected %0d", obs_pronto, exp_pronto); end
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL single_erro: got %0d expected %0d", obs_erro, exp_erro); end
      tests_run++; if (db_estado !== 4'(ESPERA_ANG0)) begin tests_failed++; $display("FAIL single_estado: got %0d expected %0d", db_estado, ESPERA_ANG0); end
   endtask

   task automatic test_back_to_back();
      send_text("045,007#180,255#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if (obs_pronto !== exp_pronto) begin tests_failed++; $display("FAIL b2b_pronto: got %0d expected %0d", obs_pronto, exp_pronto); end
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL b2b_erro: got %0d expected %0d", obs_erro, exp_erro); end
      tests_run++; if (angulo !== 12'h180) begin tests_failed++; $display("FAIL b2b_angulo: got %h expected 180", angulo); end
      tests_run++; if (distancia !== 12'h255) begin tests_failed++; $display("FAIL b2b_distancia: got %h expected 255", distancia); end
   endtask

   task automatic test_parity_error();
      send_char("0", 1'b0, 1'b0);
      send_char("9", 1'b1, 1'b0);
      repeat (4) @(negedge clock);
      tests_run++; if (db_estado !== 4'(SINCRONIZA)) begin tests_failed++; $display("FAIL parity_estado: got %0d expected %0d", db_estado, SINCRONIZA); end
      send_text("0,123#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL parity_erro: got %0d expected %0d", obs_erro, exp_erro); end
      tests_run++; if (obs_pronto !== exp_pronto) begin tests_failed++; $display("FAIL parity_pronto: got %0d expected %0d", obs_pronto, exp_pronto); end
      tests_run++; if ({angulo, distancia} !== {12'h180, 12'h255}) begin tests_failed++; $display("FAIL parity_hold: got %h/%h expected 180/255", angulo, distancia); end
      send_text("010,020#", 1);
      repeat (4) @(negedge clock);
      tests_run++; if ({angulo, distancia} !== {12'h010, 12'h020}) begin tests_failed++; $display("FAIL parity_recover: got %h/%h expected 010/020", angulo, distancia); end
      tests_run++; if (obs_pronto !== exp_pronto) begin tests_failed++; $display("FAIL parity_recover_pronto: got %0d expected %0d", obs_pronto, exp_pronto); end
   endtask

   task automatic test_bad_char();
      send_text("09A", 0);
      repeat (4) @(negedge clock);
      tests_run++; if (db_estado !== 4'(SINCRONIZA)) begin tests_failed++; $display("FAIL badchar_estado: got %0d expected %0d", db_estado, SINCRONIZA); end
      send_text(",123#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL badchar_erro: got %0d expected %0d", obs_erro, exp_erro); end
      tests_run++; if ({angulo, distancia} !== {m_ang, m_dist}) begin tests_failed++; $display("FAIL badchar_hold: got %h/%h expected %h/%h", angulo, distancia, m_ang, m_dist); end
      tests_run++; if (db_estado !== 4'(ESPERA_ANG0)) begin tests_failed++; $display("FAIL badchar_resync: got %0d expected %0d", db_estado, ESPERA_ANG0); end
   endtask

   task automatic test_empty_and_stop();
      send_text("#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL empty_erro: got %0d expected %0d", obs_erro, exp_erro); end
      tests_run++; if (db_estado !== 4'(ESPERA_ANG0)) begin tests_failed++; $display("FAIL empty_estado: got %0d expected %0d", db_estado, ESPERA_ANG0); end
      send_char("5", 1'b0, 1'b1);
      repeat (4) @(negedge clock);
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL stop_erro: got %0d expected %0d", obs_erro, exp_erro); end
      tests_run++; if (db_estado !== 4'(SINCRONIZA)) begin tests_failed++; $display("FAIL stop_estado: got %0d expected %0d", db_estado, SINCRONIZA); end
      send_text("#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL sync_hash_erro: got %0d expected %0d", obs_erro, exp_erro); end
   endtask

   task automatic test_glitch();
      int p0, e0;
      p0 = obs_pronto;
      e0 = obs_erro;
      entrada_serial = 1'b0;
      repeat (3) @(negedge clock);
      entrada_serial = 1'b1;
      repeat (3 * BAUD) @(negedge clock);
      tests_run++; if ({obs_pronto, obs_erro} !== {p0, e0}) begin tests_failed++; $display("FAIL glitch_pulses: got %0d/%0d expected %0d/%0d", obs_pronto, obs_erro, p0, e0); end
      send_text("321,654#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if ({angulo, distancia} !== {12'h321, 12'h654}) begin tests_failed++; $display("FAIL glitch_after: got %h/%h expected 321/654", angulo, distancia); end
   endtask

   task automatic test_reset_mid_frame();
      int p0, e0;
      send_text("090,12", 0);
      p0 = obs_pronto;
      e0 = obs_erro;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      tests_run++; if ({angulo, distancia} !== 24'h0) begin tests_failed++; $display("FAIL midreset_out: got %h/%h expected 000/000", angulo, distancia); end
      reset = 1'b0;
      model_reset();
      repeat (4) @(negedge clock);
      tests_run++; if ({obs_pronto, obs_erro} !== {p0, e0}) begin tests_failed++; $display("FAIL midreset_pulses: got %0d/%0d expected %0d/%0d", obs_pronto, obs_erro, p0, e0); end
      tests_run++; if (db_estado !== 4'(ESPERA_ANG0)) begin tests_failed++; $display("FAIL midreset_estado: got %0d expected %0d", db_estado, ESPERA_ANG0); end
      send_text("030,040#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if ({angulo, distancia} !== {12'h030, 12'h040}) begin tests_failed++; $display("FAIL midreset_next: got %h/%h expected 030/040", angulo, distancia); end
   endtask

   task automatic test_timeout();
      send_text("090,", 0);
      repeat (TMO + 1000) @(negedge clock);
`ifdef SONAR_RX_TIMEOUT_EN
      if (m_buf.size() != 0 && !m_sync) begin
         exp_erro++;
         m_buf.delete();
      end
`endif
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL timeout_erro: got %0d expected %0d", obs_erro, exp_erro); end
      send_text("100,200#", 0);
      repeat (4) @(negedge clock);
      tests_run++; if (obs_pronto !== exp_pronto) begin tests_failed++; $display("FAIL timeout_pronto: got %0d expected %0d", obs_pronto, exp_pronto); end
      tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL timeout_erro2: got %0d expected %0d", obs_erro, exp_erro); end
      tests_run++; if ({angulo, distancia} !== {m_ang, m_dist}) begin tests_failed++; $display("FAIL timeout_out: got %h/%h expected %h/%h", angulo, distancia, m_ang, m_dist); end
   endtask

   task automatic test_random();
      logic [7:0] c;
      int r;
      for (int f = 0; f < 12; f++) begin
         for (int k = 0; k < 8; k++) begin
            if (k == 3)      c = 8'h2C;
            else if (k == 7) c = 8'h23;
            else             c = 8'(8'h30 + $urandom_range(0, 9));
            r = $urandom_range(0, 39);
            if (r == 2) c = 8'($urandom_range(32, 126));
            send_char(c, r == 0, r == 1);
            repeat ($urandom_range(0, 2 * BAUD)) @(negedge clock);
         end
         repeat (4) @(negedge clock);
         tests_run++; if (obs_pronto !== exp_pronto) begin tests_failed++; $display("FAIL rand_pronto frame %0d: got %0d expected %0d", f, obs_pronto, exp_pronto); end
         tests_run++; if (obs_erro !== exp_erro) begin tests_failed++; $display("FAIL rand_erro frame %0d: got %0d expected %0d", f, obs_erro, exp_erro); end
         tests_run++; if ({angulo, distancia} !== {m_ang, m_dist}) begin tests_failed++; $display("FAIL rand_out frame %0d: got %h/%h expected %h/%h", f, angulo, distancia, m_ang, m_dist); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_parity_error();
      test_bad_char();
      test_empty_and_stop();
      test_glitch();
      test_reset_mid_frame();
      test_timeout();
      test_random();
      tests_run++; if (obs_both !== 0) begin tests_failed++; $display("FAIL pulse_overlap: got %0d cycles expected 0", obs_both); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
